// File: rtl/register_file_mp.sv
// Multi-port register file with a second write-back port, a pending-result
// scoreboard and a self-clearing start-up sequence.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 3,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd,
    output logic [N_RD-1:0]          rbusy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_hazard,
    output logic                     ready,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic run;
    logic w0_ok, w1_ok, clr1, iss_ok;

    assign run = (state_q == RUN);

    // Address 0 is hard-wired when ZERO_REG is set.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign w0_ok  = run && we0 && !is_zero(wa0);
    assign w1_ok  = run && we1 && !is_zero(wa1);
    assign clr1   = run && we1;
    assign iss_ok = run && iss_en && !is_zero(iss_addr);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = RUN;
                    clr_idx_d = '0;
                end
            end
            RUN: ;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        cnt_d  = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (clr1 && (wa1 == ADDR_W'(a)))
                pend_d[a] = 1'b0;
            if (iss_ok && (iss_addr == ADDR_W'(a)))
                pend_d[a] = 1'b1;
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[a]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            pend_q    <= '0;
            pend_cnt  <= '0;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pend_q    <= pend_d;
            pend_cnt  <= cnt_d;
            ready     <= (state_d == RUN);
        end
    end

    // Port 0 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                mem[clr_idx_q] <= '0;
            end else begin
                if (w1_ok)
                    mem[wa1] <= wd1;
                if (w0_ok)
                    mem[wa0] <= wd0;
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < N_RD; i++) begin
            a = ra[i*ADDR_W +: ADDR_W];
            if (!run || is_zero(a))
                rd[i*DATA_W +: DATA_W] = '0;
            else if (w0_ok && (wa0 == a))
                rd[i*DATA_W +: DATA_W] = wd0;
            else if (w1_ok && (wa1 == a))
                rd[i*DATA_W +: DATA_W] = wd1;
            else
                rd[i*DATA_W +: DATA_W] = mem[a];
            rbusy[i] = run && !is_zero(a) && pend_q[a]
                       && !(clr1 && (wa1 == a));
        end
    end

    assign iss_hazard = iss_ok && pend_q[iss_addr]
                        && !(clr1 && (wa1 == iss_addr));

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: an integer (ZERO_REG=1) and a
// float (ZERO_REG=0) instance driven by the same stimulus.
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR*AW-1:0] ra;
    logic          we0, we1, iss_en;
    logic [AW-1:0] wa0, wa1, iss_addr;
    logic [DW-1:0] wd0, wd1;

    logic [NR*DW-1:0] rd_i, rd_f;
    logic [NR-1:0]    rbusy_i, rbusy_f;
    logic             haz_i, haz_f, rdy_i, rdy_f;
    logic [AW:0]      cnt_i, cnt_f;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_i), .rbusy(rbusy_i),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_hazard(haz_i),
        .ready(rdy_i), .pend_cnt(cnt_i)
    );

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_f), .rbusy(rbusy_f),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_hazard(haz_f),
        .ready(rdy_f), .pend_cnt(cnt_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_en = 0;
        wa0 = 0; wa1 = 0; iss_addr = 0;
        wd0 = 0; wd1 = 0;
    endtask

    function automatic logic [31:0] rdp(input logic [NR*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic setra(input int i, input logic [AW-1:0] a);
        ra[i*AW +: AW] = a;
    endtask

    initial begin
        rst_n = 0;
        ra = '0;
        idle();
        step();
        step();
        chk("rst_ready", {31'b0, rdy_i}, 0);
        chk("rst_cnt", {26'b0, cnt_i}, 0);
        chk("rst_rbusy", {29'b0, rbusy_i}, 0);
        chk("rst_rd", rdp(rd_i, 0), 0);

        // Clear sequence with traffic that must be ignored.
        rst_n = 1;
        we0 = 1; wa0 = 3; wd0 = 32'hFFFF_FFFF;
        iss_en = 1; iss_addr = 3;
        setra(0, 3);
        #1;
        chk("clr_rd", rdp(rd_i, 0), 0);
        chk("clr_haz", {31'b0, haz_i}, 0);
        for (int k = 0; k < 32; k++) begin
            chk("clr_ready_low", {31'b0, rdy_i}, 0);
            step();
        end
        chk("clr_ready_high", {31'b0, rdy_i}, 1);
        idle();
        #1;
        chk("clr_cnt", {26'b0, cnt_i}, 0);
        for (int a = 0; a < 32; a++) begin
            setra(0, AW'(a));
            #1;
            chk("clr_all_zero", rdp(rd_f, 0), 0);
        end

        // Bypass priority: port 0 wins a same-address collision.
        we0 = 1; wa0 = 5; wd0 = 32'hAAAA_0000;
        we1 = 1; wa1 = 5; wd1 = 32'h5555_FFFF;
        setra(0, 5);
        #1;
        chk("byp_same_cycle", rdp(rd_i, 0), 32'hAAAA_0000);
        step();
        idle();
        #1;
        chk("byp_stored", rdp(rd_i, 0), 32'hAAAA_0000);
        we1 = 1; wa1 = 6; wd1 = 32'h0000_0066;
        setra(1, 6);
        #1;
        chk("byp_port1", rdp(rd_i, 1), 32'h0000_0066);
        step();
        idle();

        // Scoreboard set and clear.
        iss_en = 1; iss_addr = 7;
        #1;
        chk("sb_first_haz", {31'b0, haz_i}, 0);
        step();
        idle();
        setra(2, 7);
        #1;
        chk("sb_busy", {31'b0, rbusy_i[2]}, 1);
        chk("sb_cnt1", {26'b0, cnt_i}, 1);
        we1 = 1; wa1 = 7; wd1 = 32'h1234_5678;
        #1;
        chk("sb_busy_clr", {31'b0, rbusy_i[2]}, 0);
        chk("sb_rd_byp", rdp(rd_i, 2), 32'h1234_5678);
        step();
        idle();
        #1;
        chk("sb_cnt0", {26'b0, cnt_i}, 0);
        chk("sb_rd_mem", rdp(rd_i, 2), 32'h1234_5678);

        // Issue/clear collision and WAW hazard.
        iss_en = 1; iss_addr = 9;
        step();
        idle();
        #1;
        chk("col_cnt_pre", {26'b0, cnt_i}, 1);
        we1 = 1; wa1 = 9; wd1 = 32'h99;
        iss_en = 1; iss_addr = 9;
        #1;
        chk("col_no_haz", {31'b0, haz_i}, 0);
        step();
        idle();
        setra(0, 9);
        #1;
        chk("col_cnt", {26'b0, cnt_i}, 1);
        chk("col_busy", {31'b0, rbusy_i[0]}, 1);
        chk("col_rd", rdp(rd_i, 0), 32'h99);
        iss_en = 1; iss_addr = 9;
        #1;
        chk("waw_haz", {31'b0, haz_i}, 1);
        idle();
        we1 = 1; wa1 = 9; wd1 = 32'h99;
        step();
        idle();
        #1;
        chk("col_drain", {26'b0, cnt_i}, 0);

        // Register 0 behaviour on both flavours.
        we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF;
        iss_en = 1; iss_addr = 0;
        setra(0, 0);
        #1;
        chk("z_rd_byp", rdp(rd_i, 0), 0);
        chk("z_haz", {31'b0, haz_i}, 0);
        chk("f_rd_byp", rdp(rd_f, 0), 32'hFFFF_FFFF);
        step();
        idle();
        #1;
        chk("z_rd", rdp(rd_i, 0), 0);
        chk("z_busy", {31'b0, rbusy_i[0]}, 0);
        chk("z_cnt", {26'b0, cnt_i}, 0);
        chk("f_rd", rdp(rd_f, 0), 32'hFFFF_FFFF);
        chk("f_busy", {31'b0, rbusy_f[0]}, 1);
        chk("f_cnt", {26'b0, cnt_f}, 1);

        // Reset in the middle of RUN.
        for (int k = 10; k < 13; k++) begin
            iss_en = 1; iss_addr = AW'(k);
            step();
        end
        idle();
        we0 = 1; wa0 = 4; wd0 = 32'h0000_DEAD;
        step();
        idle();
        setra(0, 4);
        #1;
        chk("mr_cnt3", {26'b0, cnt_i}, 3);
        chk("mr_cnt_f", {26'b0, cnt_f}, 4);
        chk("mr_rd", rdp(rd_i, 0), 32'h0000_DEAD);
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        chk("mr_cnt0", {26'b0, cnt_i}, 0);
        chk("mr_ready0", {31'b0, rdy_i}, 0);
        chk("mr_rd_clear", rdp(rd_i, 0), 0);
        for (int k = 0; k < 32; k++) step();
        chk("mr_ready1", {31'b0, rdy_i}, 1);
        chk("mr_reg4", rdp(rd_i, 0), 0);
        chk("mr_reg4_f", rdp(rd_f, 0), 0);
        chk("mr_cnt_f0", {26'b0, cnt_f}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
